load_sequencer_tx: RTL and testbench
====================================

LOAD_SEQUENCER_TX -- requirements
Module: load_sequencer_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per serial load frame (2..32).
REQ-002 SHALL have parameter PRE_CYCLES, default 1, meaning length in clk cycles of the preset pulse (1..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  parallel word offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_data  input  WIDTH  word to transmit, MSB first.
REQ-008 SHALL have port in_preset  input  1  precede frame with preset pulse, sampled with in_data.
REQ-009 SHALL have port pre_n  output  1  active-low preset strobe to downstream flip-flops.
REQ-010 SHALL have port load_n  output  1  active-low load strobe; downstream captures load_bit while low.
REQ-011 SHALL have port load_bit  output  1  serial data bit.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port done  output  1  single-cycle pulse at frame end.

Function
REQ-014 SHALL implement FSM states IDLE, PRESET, SHIFT, DONE; all outputs registered.
REQ-015 In IDLE SHALL drive in_ready=1, busy=0, pre_n=1, load_n=1, load_bit=0, done=0.
REQ-016 Accept SHALL occur on a clk edge where in_valid=1 and in_ready=1; in_data and in_preset captured into internal registers at that edge.
REQ-017 After accept, in_ready SHALL be 0 until the cycle after DONE; in_valid while in_ready=0 SHALL be ignored, no capture.
REQ-018 Accept with in_preset=1 SHALL enter PRESET: pre_n=0, load_n=1 for exactly PRE_CYCLES cycles starting the cycle after accept, then SHIFT.
REQ-019 Accept with in_preset=0 SHALL enter SHIFT directly; first load_n=0 cycle is the cycle after accept (latency 1).
REQ-020 SHIFT SHALL last exactly WIDTH cycles with load_n=0, pre_n=1, load_bit = captured bit WIDTH-1 first down to bit 0, one bit per cycle.
REQ-021 Bit counter SHALL count 0..WIDTH-1 and SHALL NOT wrap; terminal count moves to DONE.
REQ-022 DONE SHALL last one cycle: done=1, load_n=1, pre_n=1, busy=1, in_ready=0; next state IDLE.
REQ-023 busy SHALL be 1 in PRESET, SHIFT, DONE; 0 in IDLE.
REQ-024 pre_n and load_n SHALL never be 0 in the same cycle.
REQ-025 Frame length in cycles (accept to return of in_ready) SHALL be WIDTH+2, plus PRE_CYCLES when preset requested.
REQ-026 Back-to-back: in_valid held high SHALL yield accept on the first IDLE cycle after DONE; no bubble beyond that IDLE cycle.

Reset
REQ-027 clr=1 SHALL asynchronously force IDLE, pre_n=1, load_n=1, load_bit=0, done=0, busy=0, counters and data register cleared.
REQ-028 clr asserted mid-frame SHALL abort the frame with no done pulse; frame is not resumed after clr deasserts.
REQ-029 in_ready SHALL be 0 while clr=1 and rise to 1 on the first clk edge after clr deasserts.

Structure
REQ-030 State encoding (IDLE, PRESET, SHIFT, DONE) and counter width rule (ceil log2 of max(WIDTH, PRE_CYCLES)+1) SHALL live in a shared package ff_pkg.
REQ-031 Single flat module; optional sub-module shift_out_reg (WIDTH-bit parallel-load, MSB-out shift register) is permitted.

Verification
REQ-032 WIDTH=8, accept 0xA5 in_preset=0 -> load_n low cycles 1..8 after accept, load_bit 1,0,1,0,0,1,0,1; done at cycle 9.
REQ-033 Accept 0x3C in_preset=1, PRE_CYCLES=1 -> pre_n low cycle 1, load_n low cycles 2..9 carrying 0,0,1,1,1,1,0,0; done cycle 10.
REQ-034 in_valid held high with 0xFF then 0x00 -> second accept exactly one cycle after first done; serial stream 8 ones then 8 zeros.
REQ-035 clr pulse during SHIFT bit 4 of 0xA5 -> immediate load_n=1, busy=0, no done; next accept transmits new word from MSB.
REQ-036 in_valid pulsed with 0x12 during busy -> ignored; transmitted word remains the originally accepted one.
REQ-037 Every bench SHALL assert pre_n and load_n never simultaneously low.

Source files
------------

// File: rtl/ff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ff_pkg
//  Description : Shared definitions for the serial load sequencer: FSM state
//                encoding and the sizing rule for its cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESET = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // One counter serves both the preset pulse and the bit index, so it is
  // sized for whichever of the two phases is longer.
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned p);
    int unsigned m;
    m = (w > p) ? w : p;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_sequencer_tx.sv
`default_nettype none
// ============================================================================
//  Module      : load_sequencer_tx
//  Description : Accepts a parallel word on a valid/ready handshake and plays
//                it out MSB first on load_bit under an active-low load strobe,
//                optionally preceded by an active-low preset pulse.
//  Ports       : clk, clr       - clock, async active-high reset
//                in_valid/ready - word handshake
//                in_data        - word to transmit (WIDTH bits)
//                in_preset      - request preset pulse before the frame
//                pre_n, load_n  - active-low strobes to downstream flops
//                load_bit       - serial data bit
//                busy, done     - frame in progress / end-of-frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module load_sequencer_tx
  import ff_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_preset,
  output logic             pre_n,
  output logic             load_n,
  output logic             load_bit,
  output logic             busy,
  output logic             done
);

  localparam int unsigned c_cnt_w = cnt_width(WIDTH, PRE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_last_pre = c_cnt_w'(PRE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

  state_e             state_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic [WIDTH-1:0]   data_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               pre_n_q;
  logic               load_n_q;
  logic               load_bit_q;
  logic               done_q;

  // data_q is an MSB-out shift register: load_bit is always loaded from the
  // top bit as it leaves, so the bit on the wire in a cycle was presented on
  // the edge that started that cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      pre_n_q    <= 1'b1;
      load_n_q   <= 1'b1;
      load_bit_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // in_ready_q is low for the first cycle out of reset, which blocks
          // an accept until the ready flag has been raised.
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            if (in_preset) begin
              state_q <= ST_PRESET;
              pre_n_q <= 1'b0;
              data_q  <= in_data;
            end else begin
              state_q    <= ST_SHIFT;
              load_n_q   <= 1'b0;
              load_bit_q <= in_data[WIDTH-1];
              data_q     <= {in_data[WIDTH-2:0], 1'b0};
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        ST_PRESET: begin
          if (cnt_q == c_last_pre) begin
            // pre_n releases on the same edge load_n asserts: never overlap.
            state_q    <= ST_SHIFT;
            cnt_q      <= '0;
            pre_n_q    <= 1'b1;
            load_n_q   <= 1'b0;
            load_bit_q <= data_q[WIDTH-1];
            data_q     <= {data_q[WIDTH-2:0], 1'b0};
          end else begin
            cnt_q <= cnt_q + c_one;
          end
        end

        ST_SHIFT: begin
          if (cnt_q == c_last_bit) begin
            state_q    <= ST_DONE;
            load_n_q   <= 1'b1;
            load_bit_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + c_one;
            load_bit_q <= data_q[WIDTH-1];
            data_q     <= {data_q[WIDTH-2:0], 1'b0};
          end
        end

        ST_DONE: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          data_q     <= '0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign pre_n    = pre_n_q;
  assign load_n   = load_n_q;
  assign load_bit = load_bit_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_load_sequencer_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_sequencer_tx
//  Description : Self-checking bench for load_sequencer_tx. A frame-position
//                model predicts every output each cycle; directed frames are
//                additionally pinned with hand-computed literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_sequencer_tx;

  localparam int W = 8;
  localparam int P = 1;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_preset = 1'b0;
  logic         pre_n;
  logic         load_n;
  logic         load_bit;
  logic         busy;
  logic         done;

  load_sequencer_tx #(.WIDTH(W), .PRE_CYCLES(P)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_preset(in_preset),
    .pre_n    (pre_n),
    .load_n   (load_n),
    .load_bit (load_bit),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- cycle counter ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- frame-position model ----------------
  // A frame is described by its position t (cycles since accept). With
  // pl = preset length, t in 1..pl is the preset pulse, pl+1..pl+W carries
  // the bits MSB first, pl+W+1 is the done cycle.
  bit           m_active = 1'b0;
  bit           m_ready  = 1'b0;
  int           m_t      = 0;
  logic [W-1:0] m_word   = '0;
  bit           m_pre    = 1'b0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_active = 1'b0;
      m_ready  = 1'b0;
      m_t      = 0;
    end else if (m_active) begin
      if (m_t == (m_pre ? P : 0) + W + 1) begin
        m_active = 1'b0;
        m_ready  = 1'b1;
      end else begin
        m_t++;
      end
    end else if (m_ready && in_valid) begin
      m_active = 1'b1;
      m_t      = 1;
      m_word   = in_data;
      m_pre    = in_preset;
    end else begin
      m_ready = 1'b1;
    end
  end

  bit chk_en = 1'b0;
  logic e_ready, e_busy, e_pre, e_load, e_bit, e_done;
  int   pl;

  always @(negedge clk) begin
    if (chk_en) begin
      e_ready = m_ready; e_busy = 1'b0; e_pre = 1'b1;
      e_load  = 1'b1;    e_bit  = 1'b0; e_done = 1'b0;
      if (m_active) begin
        pl      = m_pre ? P : 0;
        e_ready = 1'b0;
        e_busy  = 1'b1;
        if (m_t <= pl) e_pre = 1'b0;
        else if (m_t <= pl + W) begin
          e_load = 1'b0;
          e_bit  = m_word[W - 1 - (m_t - pl - 1)];
        end else e_done = 1'b1;
      end
      chk("in_ready", int'(in_ready), int'(e_ready));
      chk("busy",     int'(busy),     int'(e_busy));
      chk("pre_n",    int'(pre_n),    int'(e_pre));
      chk("load_n",   int'(load_n),   int'(e_load));
      chk("load_bit", int'(load_bit), int'(e_bit));
      chk("done",     int'(done),     int'(e_done));
      chk("strobe_overlap", int'(!pre_n && !load_n), 0);
    end
  end

  // ---------------- frame monitor for literal checks ----------------
  int          acc_cyc = 0;
  logic [15:0] mon_stream = '0;
  int mon_load_cnt = 0, mon_first_load = -1, mon_pre_cnt = 0;
  int mon_first_pre = -1, mon_done_cnt = 0, mon_done_rel = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!load_n) begin
        mon_stream = {mon_stream[14:0], load_bit};
        mon_load_cnt++;
        if (mon_first_load < 0) mon_first_load = cyc - acc_cyc + 1;
      end
      if (!pre_n) begin
        mon_pre_cnt++;
        if (mon_first_pre < 0) mon_first_pre = cyc - acc_cyc + 1;
      end
      if (done) begin
        mon_done_cnt++;
        mon_done_rel = cyc - acc_cyc + 1;
      end
    end
  end

  task automatic clear_mon();
    mon_stream = '0; mon_load_cnt = 0; mon_first_load = -1;
    mon_pre_cnt = 0; mon_first_pre = -1; mon_done_cnt = 0; mon_done_rel = -1;
  endtask

  // Offer a word and return just after the accepting edge.
  task automatic send(input logic [W-1:0] w, input logic p, input bit drop);
    int g;
    in_valid = 1'b1; in_data = w; in_preset = p;
    g = 0;
    while (!in_ready && g < 40) begin
      @(negedge clk); #1; g++;
    end
    chk("accept_wait", int'(in_ready), 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (drop) begin
      @(negedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int g, prev;
    prev = mon_done_cnt;
    g = 0;
    while (mon_done_cnt == prev && g < 40) begin
      @(negedge clk); #1; g++;
    end
    chk("done_seen", mon_done_cnt - prev, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int acc1;

  initial begin
    // ---- reset ----
    @(posedge clk); chk_en = 1'b1;
    @(negedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_pre_n",    int'(pre_n),    1);
    chk("rst_load_n",   int'(load_n),   1);
    clr = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready_rise", int'(in_ready), 1);

    // ---- 0xA5, no preset ----
    clear_mon();
    send(8'hA5, 1'b0, 1'b1);
    wait_done();
    chk("a5_stream",     int'(mon_stream[7:0]), 'hA5);
    chk("a5_load_cnt",   mon_load_cnt,   8);
    chk("a5_first_load", mon_first_load, 1);
    chk("a5_done_rel",   mon_done_rel,   9);
    chk("a5_pre_cnt",    mon_pre_cnt,    0);
    @(negedge clk); #1;
    chk("a5_ready_back", int'(in_ready), 1);

    // ---- 0x3C with preset ----
    clear_mon();
    send(8'h3C, 1'b1, 1'b1);
    wait_done();
    chk("3c_pre_cnt",    mon_pre_cnt,    1);
    chk("3c_first_pre",  mon_first_pre,  1);
    chk("3c_first_load", mon_first_load, 2);
    chk("3c_stream",     int'(mon_stream[7:0]), 'h3C);
    chk("3c_load_cnt",   mon_load_cnt,   8);
    chk("3c_done_rel",   mon_done_rel,   10);
    @(negedge clk); #1;

    // ---- back-to-back 0xFF then 0x00 ----
    clear_mon();
    send(8'hFF, 1'b0, 1'b0);
    acc1 = acc_cyc;
    send(8'h00, 1'b0, 1'b1);
    chk("b2b_gap", acc_cyc - acc1, W + 2);
    wait_done();
    chk("b2b_stream",   int'(mon_stream), 'hFF00);
    chk("b2b_load_cnt", mon_load_cnt, 16);
    chk("b2b_done_cnt", mon_done_cnt, 2);
    @(negedge clk); #1;

    // ---- another preset frame, model-checked ----
    clear_mon();
    send(8'h96, 1'b1, 1'b1);
    wait_done();
    chk("96_stream", int'(mon_stream[7:0]), 'h96);
    @(negedge clk); #1;

    // ---- clr during the fifth bit of 0xA5 ----
    clear_mon();
    send(8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_load_n",   int'(load_n),   1);
    chk("clr_busy",     int'(busy),     0);
    chk("clr_done",     int'(done),     0);
    chk("clr_in_ready", int'(in_ready), 0);
    @(negedge clk); #1;
    clr = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("clr_no_done",  mon_done_cnt, 0);
    chk("clr_bits_out", mon_load_cnt, 5);
    clear_mon();
    send(8'hC3, 1'b0, 1'b1);
    wait_done();
    chk("c3_stream",     int'(mon_stream[7:0]), 'hC3);
    chk("c3_first_load", mon_first_load, 1);
    @(negedge clk); #1;

    // ---- in_valid while busy is ignored ----
    clear_mon();
    send(8'h81, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1 in_valid = 1'b1; in_data = 8'h12;
    @(negedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    chk("ign_stream", int'(mon_stream[7:0]), 'h81);
    repeat (12) @(negedge clk);
    #1;
    chk("ign_load_cnt", mon_load_cnt, 8);
    chk("ign_done_cnt", mon_done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
